// File: rtl/fb_muldiv_if.sv
// fb_muldiv request/response bundle.
// master drives start/op/a/b; slave returns status, result and flags.
interface fb_muldiv_if #(
  parameter int XLEN = 32
) ();
  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic [3:0]      flags;
  logic            flags_we;

  modport master (
    output start, op, a, b,
    input  busy, done, result, flags, flags_we
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, flags, flags_we
  );
endinterface

// File: rtl/fb_muldiv.sv
// Iterative unsigned MUL/MULHU/DIVU/REMU with NZCV flag output.
// Optional FB_MULDIV_EARLY_OUT_EN skips RUN for zero operands / zero divisor.
module fb_muldiv #(
  parameter int XLEN = 32,
  parameter int CNTW = 6
) (
  input  logic     clk,
  input  logic     rst,
  fb_muldiv_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] OP_MUL = 2'b00;
  localparam logic [CNTW-1:0] LAST = CNTW'(XLEN - 1);

  state_t          state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [XLEN-1:0] md_q, md_d;
  logic [1:0]      op_q, op_d;
  logic            dz_q, dz_d;
  logic [XLEN-1:0] res_q, res_d;
  logic [3:0]      flg_q, flg_d;

  logic            accept;
  logic            dz_in;
  logic [XLEN:0]   mul_sum;
  logic [XLEN-1:0] mul_hi, mul_lo;
  logic [XLEN:0]   div_sh;
  logic [XLEN+1:0] div_df;
  logic            div_ge;
  logic [XLEN-1:0] div_hi, div_lo;
  logic [XLEN-1:0] nxt_hi, nxt_lo;
  logic [XLEN-1:0] fin_res;

  function automatic logic [3:0] flags_of(
    input logic [1:0]      op,
    input logic [XLEN-1:0] res,
    input logic [XLEN-1:0] hi,
    input logic            dz
  );
    logic c;
    c = op[1] ? dz : ((op == OP_MUL) ? (|hi) : 1'b0);
    return {res[XLEN-1], (res == '0), c, 1'b0};
  endfunction

  assign accept = bus.start && (state_q != RUN);
  assign dz_in  = (bus.b == '0);

  // hi:lo holds product (MUL) or remainder:quotient (DIV); md is the other operand
  always_comb begin
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, md_q} : '0);
    mul_hi  = mul_sum[XLEN:1];
    mul_lo  = {mul_sum[0], lo_q[XLEN-1:1]};
    div_sh  = {hi_q, lo_q[XLEN-1]};
    // one guard bit so a shifted remainder >= 2^XLEN (b==0 case) cannot look negative
    div_df  = {1'b0, div_sh} - {2'b00, md_q};
    div_ge  = ~div_df[XLEN+1];
    div_hi  = div_ge ? div_df[XLEN-1:0] : div_sh[XLEN-1:0];
    div_lo  = {lo_q[XLEN-2:0], div_ge};
    nxt_hi  = op_q[1] ? div_hi : mul_hi;
    nxt_lo  = op_q[1] ? div_lo : mul_lo;
    fin_res = op_q[0] ? nxt_hi : nxt_lo;
  end

`ifdef FB_MULDIV_EARLY_OUT_EN
  logic            eo;
  logic [XLEN-1:0] eo_res;

  always_comb begin
    eo     = 1'b0;
    eo_res = '0;
    unique case (1'b1)
      !bus.op[1]: begin
        eo     = (bus.a == '0) || dz_in;
        eo_res = '0;
      end
      bus.op[1]: begin
        eo     = dz_in;
        eo_res = bus.op[0] ? bus.a : '1;
      end
      default: ;
    endcase
  end
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    md_d    = md_q;
    op_d    = op_q;
    dz_d    = dz_q;
    res_d   = res_q;
    flg_d   = flg_q;

    unique case (state_q)
      IDLE: ;
      RUN: begin
        hi_d  = nxt_hi;
        lo_d  = nxt_lo;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = DONE;
          cnt_d   = '0;
          res_d   = fin_res;
          flg_d   = flags_of(op_q, fin_res, nxt_hi, dz_q);
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (accept) begin
      state_d = RUN;
      cnt_d   = '0;
      op_d    = bus.op;
      dz_d    = dz_in;
      hi_d    = '0;
      lo_d    = bus.op[1] ? bus.a : bus.b;
      md_d    = bus.op[1] ? bus.b : bus.a;
`ifdef FB_MULDIV_EARLY_OUT_EN
      if (eo) begin
        state_d = DONE;
        res_d   = eo_res;
        flg_d   = flags_of(bus.op, eo_res, '0, dz_in);
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      md_q    <= '0;
      op_q    <= '0;
      dz_q    <= 1'b0;
      res_q   <= '0;
      flg_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      md_q    <= md_d;
      op_q    <= op_d;
      dz_q    <= dz_d;
      res_q   <= res_d;
      flg_q   <= flg_d;
    end
  end

  assign bus.busy     = (state_q == RUN);
  assign bus.done     = (state_q == DONE);
  assign bus.flags_we = (state_q == DONE);
  assign bus.result   = res_q;
  assign bus.flags    = flg_q;
endmodule
